stream_pkt_arbiter: RTL and testbench
=====================================

Name: stream_pkt_arbiter

Overview:
- Packet-atomic round-robin arbiter that shares one AXI-Stream-style datapath, such as the upsizer/downsizer pair in top, between N_REQ independent requesters.
- Each requester presents valid/ready/data/last streams.
- The block grants one requester, forwards its beats through a registered output stage until the beat flagged last is accepted, then re-arbitrates.
- It sits in front of the resizer input and tags every output beat with the source index.

Parameters:
- T_DATA_WIDTH, 32, beat width in bits.
- N_REQ, 3, number of requesters (>=2).
- ID_WIDTH, $clog2(N_REQ), width of grant/id fields (derived localparam, not overridable).

Ports:
- clk  input  1  clock; all logic on posedge.
- rst_n  input  1  synchronous active-low reset.
- s_data  input  [T_DATA_WIDTH-1:0] x [N_REQ-1:0]  per-requester beat data.
- s_last  input  1 x [N_REQ-1:0]  per-requester end-of-packet flag.
- s_valid  input  1 x [N_REQ-1:0]  per-requester beat valid.
- s_ready  output  1 x [N_REQ-1:0]  per-requester beat accepted when s_valid & s_ready.
- m_data  output  [T_DATA_WIDTH-1:0]  forwarded beat.
- m_last  output  1  forwarded end-of-packet.
- m_id  output  [ID_WIDTH-1:0]  index of requester owning m_data.
- m_valid  output  1  output beat valid.
- m_ready  input  1  downstream accept.
- busy  output  1  high while in LOCKED.

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE, m_valid=0, m_data=0, m_last=0, m_id=0, grant=0, rr_ptr=N_REQ-1 so that requester 0 has first priority. All s_ready are 0 while rst_n=0.
- Reset mid-packet discards the in-flight packet. Any beat in the output register is dropped, with no partial-packet recovery.
- s_ready[i] = (state==LOCKED) && (grant==i) && (!m_valid || m_ready). It is combinational and never depends on s_valid[i].
- FSM IDLE:
  - Search s_valid in round-robin order rr_ptr+1, rr_ptr+2, ... (mod N_REQ).
  - If any requester is valid, register grant=first found and go to LOCKED. Otherwise stay in IDLE.
  - No beat is accepted in IDLE, which gives a 1-cycle arbitration bubble per packet.
- FSM LOCKED:
  - On s_valid[grant] && s_ready[grant], load m_data/m_last from that requester, set m_id=grant, m_valid=1.
  - If the accepted beat has s_last=1, set rr_ptr=grant and go to IDLE on the same edge.
- Output register:
  - If m_valid && m_ready and no new beat is loaded, clear m_valid next cycle.
  - Load and drain may happen in the same cycle, giving full throughput of 1 beat/cycle within a packet.
  - m_data/m_last/m_id hold stable while m_valid && !m_ready, per AXI.
- Latency is 1 cycle from s-side handshake to m_valid. Packet start costs 1 extra IDLE cycle.
- Non-granted requesters: s_ready=0. Their valid/data must be held by the source and are ignored.
- Granted requester drops s_valid mid-packet: stay LOCKED and wait indefinitely. There is no timeout.
- Simultaneous last-beat accept and new request from any requester: arbitration happens in the following IDLE cycle using the updated rr_ptr. The same requester can win again only if no other requester is valid.
- Single-beat packet (s_last on first beat): LOCKED for exactly 1 accepted beat.
- busy = (state==LOCKED).

Test Plan:
- Reset then idle, all s_valid=0: s_ready=0, m_valid=0, busy=0, and state stays IDLE for 20 cycles.
- Req0 sends 3-beat packet 0x1,0x2,0x3(last), m_ready=1: grant in cycle 1. m_data 0x1,0x2,0x3 with m_id=0 on 3 consecutive cycles, m_last only on 0x3, then busy=0.
- Req0 and req2 both valid from reset, each with a 2-beat packet (0xA0,0xA1 / 0xC0,0xC1): req0 is served first, then req2 after 1 IDLE bubble. Output order is 0xA0,0xA1,0xC0,0xC1 with m_id 0,0,2,2.
- All three requesters continuously valid with 1-beat packets: m_id sequence 0,1,2,0,1,2, one beat every 2 cycles.
- Backpressure: m_ready=0 for 4 cycles while m_valid holds 0x2: m_data stays 0x2 and s_ready[grant]=0. After m_ready=1, 0x3 follows with no loss or duplication.
- Reset asserted after beat 0x1 of a 3-beat req1 packet: next cycle m_valid=0 and busy=0. After release, req0 wins the next arbitration while req0 and req1 are both valid.

Source files
------------

// File: rtl/stream_pkt_arbiter.sv
// Packet-atomic round-robin arbiter sharing one stream datapath among N_REQ
// requesters. A requester, once granted, keeps the path until its last beat is
// accepted; each forwarded beat is tagged with the index of its source.
module stream_pkt_arbiter #(
    parameter int T_DATA_WIDTH = 32,
    parameter int N_REQ        = 3,
    localparam int ID_WIDTH    = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [T_DATA_WIDTH-1:0] s_data [N_REQ-1:0],
    input  logic [N_REQ-1:0]        s_last,
    input  logic [N_REQ-1:0]        s_valid,
    output logic [N_REQ-1:0]        s_ready,
    output logic [T_DATA_WIDTH-1:0] m_data,
    output logic                    m_last,
    output logic [ID_WIDTH-1:0]     m_id,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    busy
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t              state;
    logic [ID_WIDTH-1:0] grant;
    logic [ID_WIDTH-1:0] rr_ptr;

    logic                out_free;
    logic                take;
    logic                rr_found;
    logic [ID_WIDTH-1:0] rr_idx;

    // The output register can take a new beat when empty or draining this cycle.
    assign out_free = !m_valid || m_ready;
    assign take     = s_valid[grant] && s_ready[grant];
    assign busy     = (state == LOCKED);

    // Only the granted requester sees ready, and only when the output slot frees up.
    always_comb begin
        s_ready = '0;
        if (rst_n && (state == LOCKED) && out_free) begin
            s_ready[grant] = 1'b1;
        end
    end

    // Round-robin search starting just after the last packet's owner.
    always_comb begin
        int                  cand;
        logic [ID_WIDTH-1:0] cand_id;
        rr_found = 1'b0;
        rr_idx   = '0;
        cand     = 0;
        cand_id  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            cand_id = ID_WIDTH'(cand);
            if (!rr_found && s_valid[cand_id]) begin
                rr_found = 1'b1;
                rr_idx   = cand_id;
            end
        end
    end

    // Arbitration FSM plus registered output stage; reset drops any in-flight beat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            grant   <= '0;
            rr_ptr  <= ID_WIDTH'(N_REQ - 1);
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
            m_id    <= '0;
        end else begin
            if (m_ready) begin
                m_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (rr_found) begin
                        grant <= rr_idx;
                        state <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (take) begin
                        m_data  <= s_data[grant];
                        m_last  <= s_last[grant];
                        m_id    <= grant;
                        m_valid <= 1'b1;
                        if (s_last[grant]) begin
                            rr_ptr <= grant;
                            state  <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_pkt_arbiter.sv
// Scoreboard bench for stream_pkt_arbiter: packet-level round-robin model,
// randomized sources and downstream backpressure, plus directed timing cases.
module tb_stream_pkt_arbiter;

    localparam int N = 3;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] s_data [N-1:0];
    logic [N-1:0] s_last;
    logic [N-1:0] s_valid;
    logic [N-1:0] s_ready;
    logic [W-1:0] m_data;
    logic         m_last;
    logic [1:0]   m_id;
    logic         m_valid;
    logic         m_ready;
    logic         busy;

    stream_pkt_arbiter #(.T_DATA_WIDTH(W), .N_REQ(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_data(s_data), .s_last(s_last), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_last(m_last), .m_id(m_id), .m_valid(m_valid),
        .m_ready(m_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // source beat queues (driven), staging queues (for the model), expected output
    logic [W-1:0] q_d   [N][$];
    bit           q_l   [N][$];
    logic [W-1:0] stg_d [N][$];
    bit           stg_l [N][$];
    bit           started [N];
    logic [W-1:0] exp_d [$];
    bit           exp_l [$];
    int           exp_id [$];
    int           out_cyc [$];
    int           m_ptr;
    bit           drop_en;
    bit           mr_rand;
    bit           mr_val;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // source driver and downstream ready generator
    initial begin
        logic [N-1:0] acc;
        s_valid = '0;
        s_last  = '0;
        m_ready = 1'b0;
        for (int i = 0; i < N; i++) s_data[i] = '0;
        forever begin
            @(negedge clk);
            acc = s_valid & s_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (acc[i] && q_d[i].size() > 0) begin
                    started[i] = !q_l[i][0];
                    q_d[i].delete(0);
                    q_l[i].delete(0);
                end
                if (q_d[i].size() == 0) begin
                    s_valid[i] = 1'b0;
                end else if (s_valid[i] && !acc[i]) begin
                    s_valid[i] = 1'b1;
                end else if (started[i] && drop_en && $urandom_range(0, 2) == 0) begin
                    s_valid[i] = 1'b0;
                end else begin
                    s_valid[i] = 1'b1;
                    s_data[i]  = q_d[i][0];
                    s_last[i]  = q_l[i][0];
                end
            end
            #2;
            m_ready = mr_rand ? ($urandom_range(0, 3) != 0) : mr_val;
        end
    end

    // monitor: compare every accepted output beat against the scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (m_valid === 1'b1 && m_ready === 1'b1) begin
                out_cyc.push_back(cyc);
                if (exp_d.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got data %0h id %0d, required no beat", m_data, m_id);
                end else begin
                    chk("sb_data", 64'(m_data), 64'(exp_d.pop_front()));
                    chk("sb_last", 64'(m_last), 64'(exp_l.pop_front()));
                    chk("sb_id", 64'(m_id), 64'(exp_id.pop_front()));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic stage(input int r, input logic [W-1:0] d, input bit l);
        stg_d[r].push_back(d);
        stg_l[r].push_back(l);
    endtask

    // Hand staged packets to the sources and predict the output order: every
    // requester with packets left is valid at each arbitration, so the next
    // owner is the first requester after the previous owner that still has one.
    task automatic commit();
        int r;
        bit found;
        bit l;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < stg_d[i].size(); j++) begin
                q_d[i].push_back(stg_d[i][j]);
                q_l[i].push_back(stg_l[i][j]);
            end
        end
        found = 1'b1;
        while (found) begin
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
                r = (m_ptr + k) % N;
                if (!found && stg_d[r].size() > 0) begin
                    found = 1'b1;
                    m_ptr = r;
                    l = 1'b0;
                    while (!l && stg_d[r].size() > 0) begin
                        exp_d.push_back(stg_d[r].pop_front());
                        l = stg_l[r].pop_front();
                        exp_l.push_back(l);
                        exp_id.push_back(r);
                    end
                end
            end
        end
    endtask

    task automatic clear_sources();
        for (int i = 0; i < N; i++) begin
            q_d[i].delete();
            q_l[i].delete();
            stg_d[i].delete();
            stg_l[i].delete();
            started[i] = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_sources();
        tick();
        tick();
        exp_d.delete();
        exp_l.delete();
        exp_id.delete();
        m_ptr = N - 1;
        rst_n = 1'b1;
    endtask

    task automatic wait_drain(input int budget);
        int  n;
        bit  pend;
        n = 0;
        pend = 1'b1;
        while (pend && n <= budget) begin
            pend = (exp_d.size() > 0);
            for (int i = 0; i < N; i++) if (q_d[i].size() > 0) pend = 1'b1;
            if (pend) begin
                tick();
                n++;
            end
        end
        chk("drain_timeout", 64'(pend), 64'd0);
        tick();
    endtask

    function automatic int oc(input int k);
        return (k < out_cyc.size()) ? out_cyc[k] : -1;
    endfunction

    initial begin
        int  t0;
        bit  found;
        int  npk;
        int  len;
        rst_n   = 1'b0;
        drop_en = 1'b0;
        mr_rand = 1'b0;
        mr_val  = 1'b1;
        m_ptr   = N - 1;
        clear_sources();

        // reset state
        tick();
        tick();
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_data", 64'(m_data), 64'd0);
        chk("rst_m_last", 64'(m_last), 64'd0);
        chk("rst_m_id", 64'(m_id), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        rst_n = 1'b1;

        // idle with nothing requested
        for (int c = 0; c < 20; c++) begin
            tick();
            chk("idle_s_ready", 64'(s_ready), 64'd0);
            chk("idle_m_valid", 64'(m_valid), 64'd0);
            chk("idle_busy", 64'(busy), 64'd0);
        end

        // single requester, three beats back to back
        stage(0, 32'h1, 1'b0);
        stage(0, 32'h2, 1'b0);
        stage(0, 32'h3, 1'b1);
        out_cyc.delete();
        commit();
        t0 = cyc;
        wait_drain(50);
        chk("p3_count", 64'(out_cyc.size()), 64'd3);
        chk("p3_first_lat", 64'(oc(0)), 64'(t0 + 3));
        chk("p3_beat1", 64'(oc(1)), 64'(t0 + 4));
        chk("p3_beat2", 64'(oc(2)), 64'(t0 + 5));
        chk("p3_busy_after", 64'(busy), 64'd0);

        // two requesters from reset, arbitration bubble between packets
        do_reset();
        stage(0, 32'hA0, 1'b0);
        stage(0, 32'hA1, 1'b1);
        stage(2, 32'hC0, 1'b0);
        stage(2, 32'hC1, 1'b1);
        out_cyc.delete();
        commit();
        t0 = cyc;
        wait_drain(50);
        chk("two_count", 64'(out_cyc.size()), 64'd4);
        chk("two_first_lat", 64'(oc(0)), 64'(t0 + 3));
        chk("two_bubble", 64'(oc(2) - oc(1)), 64'd2);
        chk("two_c1", 64'(oc(3) - oc(2)), 64'd1);

        // all requesters busy with single-beat packets: one beat every 2 cycles
        do_reset();
        for (int p = 0; p < 2; p++)
            for (int r = 0; r < N; r++) stage(r, 32'h40 + 32'(p * N + r), 1'b1);
        out_cyc.delete();
        commit();
        wait_drain(60);
        chk("rr_count", 64'(out_cyc.size()), 64'd6);
        for (int j = 1; j < 6; j++) chk("rr_gap", 64'(oc(j) - oc(j - 1)), 64'd2);

        // downstream backpressure while 0x2 sits in the output register
        stage(0, 32'h1, 1'b0);
        stage(0, 32'h2, 1'b0);
        stage(0, 32'h3, 1'b1);
        out_cyc.delete();
        commit();
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            tick();
            if (m_valid === 1'b1 && m_data === 32'h2) found = 1'b1;
        end
        chk("bp_found", 64'(found), 64'd1);
        mr_val = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("bp_m_valid", 64'(m_valid), 64'd1);
            chk("bp_m_data", 64'(m_data), 64'h2);
            chk("bp_s_ready", 64'(s_ready), 64'd0);
        end
        mr_val = 1'b1;
        wait_drain(50);
        chk("bp_count", 64'(out_cyc.size()), 64'd3);

        // reset in the middle of a req1 packet
        do_reset();
        stage(1, 32'h11, 1'b0);
        stage(1, 32'h12, 1'b0);
        stage(1, 32'h13, 1'b1);
        commit();
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            tick();
            if (m_valid === 1'b1) found = 1'b1;
        end
        chk("mid_found", 64'(found), 64'd1);
        rst_n = 1'b0;
        clear_sources();
        tick();
        chk("mid_m_valid", 64'(m_valid), 64'd0);
        chk("mid_busy", 64'(busy), 64'd0);
        chk("mid_s_ready", 64'(s_ready), 64'd0);
        chk("mid_sb_pending", 64'(exp_d.size()), 64'd2);
        exp_d.delete();
        exp_l.delete();
        exp_id.delete();
        m_ptr = N - 1;
        rst_n = 1'b1;
        stage(0, 32'h21, 1'b1);
        stage(1, 32'h31, 1'b0);
        stage(1, 32'h32, 1'b1);
        commit();
        wait_drain(50);

        // randomized packets, mid-packet source gaps and random backpressure
        drop_en = 1'b1;
        mr_rand = 1'b1;
        for (int b = 0; b < 8; b++) begin
            for (int r = 0; r < N; r++) begin
                npk = $urandom_range(0, 3);
                for (int p = 0; p < npk; p++) begin
                    len = $urandom_range(1, 4);
                    for (int k = 0; k < len; k++) stage(r, $urandom, (k == len - 1));
                end
            end
            commit();
            wait_drain(1000);
        end
        chk("final_sb_empty", 64'(exp_d.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
